// File: rtl/tartaruga_pkg.sv
// rtl/tartaruga_pkg.sv - shared core types and the reorder-buffer entry layout
// ROB_EXCEPTION_EN adds per-entry exception flag and cause.
package tartaruga_pkg;

  typedef logic [31:0] bus32_t;
  typedef logic [31:0] instruction_t;
  typedef logic [4:0]  reg_addr_t;
  typedef logic [4:0]  exc_cause_t;

  localparam int ROB_DEPTH_DEFAULT = 16;

  typedef struct packed {
    logic         valid;
    logic         done;
    bus32_t       pc;
    instruction_t instr;
    reg_addr_t    rd;
    logic         we;
    logic         store;
    bus32_t       result;
    bus32_t       new_pc;
    logic         taken;
`ifdef ROB_EXCEPTION_EN
    logic         exc;
    exc_cause_t   cause;
`endif
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// rtl/rob_ptr_ctrl.sv - head/tail/occupancy tracking for the reorder buffer
// Pointers carry a wrap bit so full and empty are distinguishable with equal indices.
module rob_ptr_ctrl #(
  parameter int  DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             flush_i,
  input  logic             alloc_req_i,
  input  logic             commit_i,
  output logic             alloc_o,
  output logic [IDX_W-1:0] head_idx_o,
  output logic [IDX_W-1:0] tail_idx_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [IDX_W:0]   count_o
);

  logic [IDX_W:0] head_q, tail_q, count_q;

  assign head_idx_o = head_q[IDX_W-1:0];
  assign tail_idx_o = tail_q[IDX_W-1:0];
  assign full_o     = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign empty_o    = (head_q == tail_q);
  assign count_o    = count_q;
  // full comes from registered pointers, so a same-cycle commit cannot make room
  assign alloc_o    = alloc_req_i && !full_o;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (alloc_o)  tail_q <= tail_q + (IDX_W+1)'(1);
      if (commit_i) head_q <= head_q + (IDX_W+1)'(1);
      count_q <= count_q + (IDX_W+1)'(alloc_o) - (IDX_W+1)'(commit_i);
    end
  end

endmodule

// File: rtl/rob_multiport.sv
// rtl/rob_multiport.sv - reorder buffer: in-order alloc, NUM_WB out-of-order writebacks, in-order commit
// ROB_EXCEPTION_EN adds exception capture on writeback and reporting on commit.
module rob_multiport
  import tartaruga_pkg::*;
#(
  parameter int  DEPTH  = ROB_DEPTH_DEFAULT,
  parameter int  NUM_WB = 2,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           flush_i,
  input  logic                           valid_decode_i,
  input  bus32_t                         pc_i,
  input  instruction_t                   instr_i,
  input  reg_addr_t                      rd_addr_i,
  input  logic                           write_enable_i,
  input  logic                           store_to_mem_i,
  output logic                           alloc_ready_o,
  output logic [IDX_W-1:0]               rob_entry_alloc_o,
  input  logic [NUM_WB-1:0]              valid_wb_i,
  input  logic [NUM_WB-1:0][IDX_W-1:0]   rob_entry_wb_i,
  input  bus32_t [NUM_WB-1:0]            result_i,
  input  bus32_t [NUM_WB-1:0]            new_pc_i,
  input  logic [NUM_WB-1:0]              branch_taken_i,
`ifdef ROB_EXCEPTION_EN
  input  logic [NUM_WB-1:0]              exc_valid_i,
  input  exc_cause_t [NUM_WB-1:0]        exc_cause_i,
  output logic                           commit_exception_o,
  output exc_cause_t                     commit_exc_cause_o,
`endif
  input  logic                           commit_ready_i,
  output logic                           commit_valid_o,
  output bus32_t                         commit_pc_o,
  output instruction_t                   commit_instr_o,
  output reg_addr_t                      commit_rd_addr_o,
  output bus32_t                         commit_result_o,
  output logic                           commit_write_enable_o,
  output logic                           commit_store_to_mem_o,
  output bus32_t                         commit_new_pc_o,
  output logic                           commit_branch_taken_o,
  output logic                           rob_full_o,
  output logic                           rob_empty_o,
  output logic [IDX_W:0]                 rob_count_o
);

  rob_entry_t             entries [DEPTH];
  rob_entry_t             head_e, alloc_e;
  logic [IDX_W-1:0]       head_idx, tail_idx;
  logic                   alloc_fire, commit_fire;
  logic [NUM_WB-1:0]      wb_hit;

  rob_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .flush_i     (flush_i),
    .alloc_req_i (valid_decode_i),
    .commit_i    (commit_fire),
    .alloc_o     (alloc_fire),
    .head_idx_o  (head_idx),
    .tail_idx_o  (tail_idx),
    .full_o      (rob_full_o),
    .empty_o     (rob_empty_o),
    .count_o     (rob_count_o)
  );

  assign alloc_ready_o     = !rob_full_o;
  assign rob_entry_alloc_o = tail_idx;
  assign head_e            = entries[head_idx];
  assign commit_valid_o    = head_e.valid && head_e.done && !flush_i;
  assign commit_fire       = commit_valid_o && commit_ready_i;

  always_comb begin
    alloc_e       = '0;
    alloc_e.valid = 1'b1;
    alloc_e.pc    = pc_i;
    alloc_e.instr = instr_i;
    alloc_e.rd    = rd_addr_i;
    alloc_e.we    = write_enable_i;
    alloc_e.store = store_to_mem_i;
  end

  // a writeback only lands on an entry that is allocated and still pending
  always_comb begin
    wb_hit = '0;
    for (int p = 0; p < NUM_WB; p++)
      wb_hit[p] = valid_wb_i[p] && entries[rob_entry_wb_i[p]].valid && !entries[rob_entry_wb_i[p]].done;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
    end else begin
      // descending order lets the lowest-numbered port win a shared target
      for (int p = NUM_WB-1; p >= 0; p--) begin
        if (wb_hit[p]) begin
          entries[rob_entry_wb_i[p]].done   <= 1'b1;
          entries[rob_entry_wb_i[p]].result <= result_i[p];
          entries[rob_entry_wb_i[p]].new_pc <= new_pc_i[p];
          entries[rob_entry_wb_i[p]].taken  <= branch_taken_i[p];
`ifdef ROB_EXCEPTION_EN
          entries[rob_entry_wb_i[p]].exc    <= exc_valid_i[p];
          entries[rob_entry_wb_i[p]].cause  <= exc_cause_i[p];
`endif
        end
      end
      if (commit_fire) entries[head_idx].valid <= 1'b0;
      if (alloc_fire)  entries[tail_idx] <= alloc_e;
    end
  end

  assign commit_pc_o           = commit_valid_o ? head_e.pc     : '0;
  assign commit_instr_o        = commit_valid_o ? head_e.instr  : '0;
  assign commit_rd_addr_o      = commit_valid_o ? head_e.rd     : '0;
  assign commit_result_o       = commit_valid_o ? head_e.result : '0;
  assign commit_new_pc_o       = commit_valid_o ? head_e.new_pc : '0;
  assign commit_branch_taken_o = commit_valid_o && head_e.taken;
`ifdef ROB_EXCEPTION_EN
  // an excepting instruction retires without architectural side effects
  assign commit_write_enable_o = commit_valid_o && head_e.we && !head_e.exc;
  assign commit_store_to_mem_o = commit_valid_o && head_e.store && !head_e.exc;
  assign commit_exception_o    = commit_valid_o && head_e.exc;
  assign commit_exc_cause_o    = commit_valid_o ? head_e.cause : '0;
`else
  assign commit_write_enable_o = commit_valid_o && head_e.we;
  assign commit_store_to_mem_o = commit_valid_o && head_e.store;
`endif

endmodule

// File: tb/tb_rob_multiport.sv
// tb/tb_rob_multiport.sv - self-checking bench for rob_multiport against a queue-based reference model
module tb_rob_multiport;
  import tartaruga_pkg::*;

  localparam int DEPTH = 16, NUM_WB = 2, IDX_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, flush, vd, we, st, ready;
  logic [31:0] pc, instr;
  logic [4:0]  rd;
  logic [NUM_WB-1:0] vwb, tk;
  logic [NUM_WB-1:0][IDX_W-1:0] wbidx;
  logic [NUM_WB-1:0][31:0] res, npc;
  logic alloc_ready, c_valid, c_we, c_st, c_tk, full, empty;
  logic [IDX_W-1:0] alloc_idx;
  logic [31:0] c_pc, c_instr, c_res, c_npc;
  logic [4:0]  c_rd;
  logic [IDX_W:0] count;
`ifdef ROB_EXCEPTION_EN
  logic [NUM_WB-1:0] exc_v;
  logic [NUM_WB-1:0][4:0] exc_c;
  logic c_exc;
  logic [4:0] c_cause;
`endif

  rob_multiport #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) dut (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .valid_decode_i(vd),
    .pc_i(pc), .instr_i(instr), .rd_addr_i(rd), .write_enable_i(we), .store_to_mem_i(st),
    .alloc_ready_o(alloc_ready), .rob_entry_alloc_o(alloc_idx),
    .valid_wb_i(vwb), .rob_entry_wb_i(wbidx), .result_i(res), .new_pc_i(npc), .branch_taken_i(tk),
`ifdef ROB_EXCEPTION_EN
    .exc_valid_i(exc_v), .exc_cause_i(exc_c), .commit_exception_o(c_exc), .commit_exc_cause_o(c_cause),
`endif
    .commit_ready_i(ready), .commit_valid_o(c_valid), .commit_pc_o(c_pc), .commit_instr_o(c_instr),
    .commit_rd_addr_o(c_rd), .commit_result_o(c_res), .commit_write_enable_o(c_we),
    .commit_store_to_mem_o(c_st), .commit_new_pc_o(c_npc), .commit_branch_taken_o(c_tk),
    .rob_full_o(full), .rob_empty_o(empty), .rob_count_o(count)
  );

  typedef struct {
    int idx; bit done; logic [31:0] pc, instr; logic [4:0] rd; bit we, st;
    logic [31:0] res, npc; bit tk, exc; logic [4:0] cause;
  } m_ent_t;

  m_ent_t q[$];
  int m_tail;
  int checks, errors;

  task automatic idle();
    vd = 0; vwb = '0; flush = 0;
`ifdef ROB_EXCEPTION_EN
    exc_v = '0; exc_c = '0;
`endif
  endtask

  task automatic set_alloc(input logic [31:0] p, input logic [4:0] r);
    vd = 1; pc = p; instr = $urandom; rd = r; we = 1'($urandom); st = 1'($urandom);
  endtask

  task automatic set_wb(input int port, input int idx, input logic [31:0] v);
    vwb[port] = 1; wbidx[port] = IDX_W'(idx); res[port] = v; npc[port] = $urandom; tk[port] = 1'($urandom);
  endtask

  // compare every observable output with the model, then advance model and DUT one clock
  task automatic cycle();
    bit exp_cv, mfull;
    logic [135:0] got, exp;
    m_ent_t e;
    #1;
    exp_cv = (q.size() > 0) && q[0].done && !flush;
    mfull  = (q.size() == DEPTH);
    checks++; if (c_valid !== exp_cv) begin errors++; $display("FAIL commit_valid got %0b exp %0b", c_valid, exp_cv); end
    checks++; if (int'(count) !== q.size()) begin errors++; $display("FAIL count got %0d exp %0d", count, q.size()); end
    checks++; if (full !== mfull || empty !== (q.size() == 0) || alloc_ready !== !mfull) begin
      errors++; $display("FAIL flags got full=%0b empty=%0b rdy=%0b exp size %0d", full, empty, alloc_ready, q.size()); end
    checks++; if (int'(alloc_idx) !== m_tail) begin errors++; $display("FAIL alloc_idx got %0d exp %0d", alloc_idx, m_tail); end
    if (exp_cv) begin
      got = {c_pc, c_instr, c_rd, c_we, c_st, c_res, c_npc, c_tk};
      exp = {q[0].pc, q[0].instr, q[0].rd, q[0].we && !q[0].exc, q[0].st && !q[0].exc, q[0].res, q[0].npc, q[0].tk};
      checks++; if (got !== exp) begin errors++; $display("FAIL commit_fields got %h exp %h", got, exp); end
`ifdef ROB_EXCEPTION_EN
      checks++; if (c_exc !== q[0].exc || (q[0].exc && c_cause !== q[0].cause)) begin
        errors++; $display("FAIL commit_exc got %0b/%0d exp %0b/%0d", c_exc, c_cause, q[0].exc, q[0].cause); end
`endif
    end
    if (flush) begin
      q.delete(); m_tail = 0;
    end else begin
      for (int p = 0; p < NUM_WB; p++)
        if (vwb[p])
          foreach (q[k])
            if (q[k].idx == int'(wbidx[p]) && !q[k].done) begin
              q[k].done = 1; q[k].res = res[p]; q[k].npc = npc[p]; q[k].tk = tk[p];
`ifdef ROB_EXCEPTION_EN
              q[k].exc = exc_v[p]; q[k].cause = exc_c[p];
`endif
            end
      if (exp_cv && ready) void'(q.pop_front());
      if (vd && !mfull) begin
        e = '{idx: m_tail, done: 0, pc: pc, instr: instr, rd: rd, we: we, st: st,
              res: 0, npc: 0, tk: 0, exc: 0, cause: 0};
        q.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic do_flush();
    idle(); flush = 1; cycle(); idle();
  endtask

  task automatic drain();
    ready = 1;
    for (int n = 0; n < 3*DEPTH && q.size() > 0; n++) begin
      int p = 0;
      idle();
      foreach (q[k]) if (!q[k].done && p < NUM_WB) begin set_wb(p, q[k].idx, $urandom); p++; end
      cycle();
    end
    idle();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (c_valid !== 0 || count !== 0 || full !== 0) begin errors++; $display("FAIL reset_valid_count got %0b %0d %0b exp 0 0 0", c_valid, count, full); end
    checks++; if (empty !== 1 || alloc_ready !== 1) begin errors++; $display("FAIL reset_empty_ready got %0b %0b exp 1 1", empty, alloc_ready); end
    checks++; if (alloc_idx !== 0 || c_res !== 0 || c_pc !== 0) begin errors++; $display("FAIL reset_outputs got %0d %h %h exp 0", alloc_idx, c_res, c_pc); end
  endtask

  task automatic test_basic();
    ready = 1; set_alloc(32'h4, 5'd1); cycle(); idle(); #1;
    checks++; if (count !== 1) begin errors++; $display("FAIL basic_count got %0d exp 1", count); end
    set_wb(0, 0, 32'hDEADBEEF); cycle(); idle(); #1;
    checks++; if (c_valid !== 1 || c_res !== 32'hDEADBEEF || c_pc !== 32'h4) begin
      errors++; $display("FAIL basic_commit got %0b %h %h exp 1 deadbeef 4", c_valid, c_res, c_pc); end
    cycle();
  endtask

  task automatic test_out_of_order();
    do_flush(); ready = 1;
    for (int i = 0; i < 3; i++) begin set_alloc(32'h100 + 4*i, 5'(i+2)); cycle(); end
    idle();
    for (int i = 2; i >= 0; i--) begin
      #1;
      checks++; if (c_valid !== 0) begin errors++; $display("FAIL ooo_early_commit got %0b exp 0 before wb%0d", c_valid, i); end
      idle(); set_wb(i % NUM_WB, i, 32'h1000 + i); cycle();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (c_valid !== 1 || c_pc !== 32'h100 + 4*i) begin errors++; $display("FAIL ooo_order got %0b %h exp 1 %h", c_valid, c_pc, 32'h100 + 4*i); end
      cycle();
    end
  endtask

  task automatic test_fill();
    do_flush(); ready = 0;
    for (int i = 0; i <= DEPTH; i++) begin set_alloc(32'h2000 + 4*i, 5'(i)); cycle(); end
    idle(); #1;
    checks++; if (full !== 1 || count !== DEPTH || alloc_ready !== 0) begin errors++; $display("FAIL fill_full got %0b %0d %0b exp 1 16 0", full, count, alloc_ready); end
    set_wb(0, 0, 32'h55); cycle(); idle();
    ready = 1; set_alloc(32'h3000, 5'd7); cycle(); idle(); #1;
    checks++; if (count !== DEPTH-1) begin errors++; $display("FAIL fill_commit_alloc got %0d exp 15", count); end
    set_alloc(32'h3004, 5'd8); cycle(); idle(); #1;
    checks++; if (count !== DEPTH) begin errors++; $display("FAIL fill_refill got %0d exp 16", count); end
    drain();
  endtask

  task automatic test_dual_wb();
    do_flush(); ready = 0;
    for (int i = 0; i < 4; i++) begin set_alloc(32'h400 + 4*i, 5'(i)); cycle(); end
    idle(); set_wb(0, 3, 32'hCAFEBABE); set_wb(1, 3, 32'hFEEDFACE); cycle();
    idle(); set_wb(0, 0, 32'h10); set_wb(1, 1, 32'h11); cycle();
    idle(); set_wb(0, 2, 32'h12); cycle();
    idle(); ready = 1; repeat (3) cycle();
    ready = 0; #1;
    checks++; if (c_valid !== 1 || c_res !== 32'hCAFEBABE) begin errors++; $display("FAIL dual_wb got %0b %h exp 1 cafebabe", c_valid, c_res); end
    drain();
  endtask

  task automatic test_stall();
    logic [135:0] snap;
    do_flush(); ready = 0;
    set_alloc(32'h500, 5'd9); cycle(); idle();
    set_wb(1, 0, 32'h600); cycle(); idle(); #1;
    snap = {c_pc, c_instr, c_rd, c_we, c_st, c_res, c_npc, c_tk};
    repeat (3) begin
      cycle(); #1;
      checks++; if ({c_pc, c_instr, c_rd, c_we, c_st, c_res, c_npc, c_tk} !== snap || c_valid !== 1) begin
        errors++; $display("FAIL stall_hold got %h exp %h", {c_pc, c_instr, c_rd, c_we, c_st, c_res, c_npc, c_tk}, snap); end
    end
    ready = 1; cycle();
  endtask

  task automatic test_wrap();
    do_flush(); ready = 1;
    for (int i = 0; i < 40; i++) begin
      #1;
      checks++; if (int'(alloc_idx) !== i % DEPTH) begin errors++; $display("FAIL wrap_idx got %0d exp %0d", alloc_idx, i % DEPTH); end
      set_alloc(32'h8000 + 4*i, 5'(i)); cycle(); idle();
      set_wb(i % NUM_WB, i % DEPTH, $urandom); cycle(); idle();
      cycle();
    end
  endtask

  task automatic test_flush();
    do_flush(); ready = 0;
    for (int i = 0; i < 5; i++) begin set_alloc(32'h900 + 4*i, 5'(i)); cycle(); end
    idle(); set_wb(0, 0, 32'h77); cycle(); idle();
    ready = 1; flush = 1; set_alloc(32'h999, 5'd3); set_wb(0, 1, 32'h88); set_wb(1, 3, 32'h99); cycle(); idle(); #1;
    checks++; if (empty !== 1 || alloc_idx !== 0 || count !== 0 || c_valid !== 0) begin
      errors++; $display("FAIL flush_state got empty=%0b idx=%0d cnt=%0d cv=%0b exp 1 0 0 0", empty, alloc_idx, count, c_valid); end
    set_alloc(32'hA00, 5'd4); cycle(); idle(); drain();
  endtask

  task automatic test_async_reset();
    ready = 0;
    for (int i = 0; i < 3; i++) begin set_alloc(32'hB00 + 4*i, 5'(i)); cycle(); end
    idle(); set_wb(0, q[0].idx, 32'h1); cycle(); idle();
    #2 rstn = 0; #1;
    checks++; if (count !== 0 || empty !== 1 || c_valid !== 0 || alloc_ready !== 1 || alloc_idx !== 0) begin
      errors++; $display("FAIL async_reset got cnt=%0d empty=%0b cv=%0b rdy=%0b idx=%0d exp 0 1 0 1 0", count, empty, c_valid, alloc_ready, alloc_idx); end
    q.delete(); m_tail = 0;
    @(negedge clk); rstn = 1;
    cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      idle();
      if ($urandom_range(99) < 60) set_alloc($urandom, 5'($urandom));
      for (int p = 0; p < NUM_WB; p++) begin
        int r = $urandom_range(9);
        if (r < 6 && q.size() > 0) set_wb(p, q[$urandom_range(q.size()-1)].idx, $urandom);
        else if (r < 8) set_wb(p, $urandom_range(DEPTH-1), $urandom);
      end
      ready = 1'($urandom_range(99) < 55);
      flush = ($urandom_range(99) < 2);
      cycle();
    end
    idle(); drain();
  endtask

`ifdef ROB_EXCEPTION_EN
  task automatic test_exception();
    do_flush(); ready = 0;
    set_alloc(32'hC00, 5'd5); we = 1; st = 1; cycle(); idle();
    set_wb(0, 0, 32'h42); exc_v[0] = 1; exc_c[0] = 5'd2; cycle(); idle(); #1;
    checks++; if (c_exc !== 1 || c_cause !== 5'd2 || c_we !== 0 || c_st !== 0) begin
      errors++; $display("FAIL exception got exc=%0b cause=%0d we=%0b st=%0b exp 1 2 0 0", c_exc, c_cause, c_we, c_st); end
    ready = 1; cycle();
  endtask
`endif

  initial begin
    checks = 0; errors = 0; m_tail = 0;
    rstn = 0; ready = 0; pc = 0; instr = 0; rd = 0; we = 0; st = 0;
    wbidx = '0; res = '0; npc = '0; tk = '0;
    idle();
    repeat (2) @(negedge clk);
    rstn = 1;
    test_reset();
    test_basic();
    test_out_of_order();
    test_fill();
    test_dual_wb();
    test_stall();
    test_wrap();
    test_flush();
    test_async_reset();
`ifdef ROB_EXCEPTION_EN
    test_exception();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
